// File: rtl/array_check_scheduler_pkg.sv
// Shared constants for the array-check scheduler: one-hot state encoding and
// parameter defaults.
package array_check_scheduler_pkg;

    localparam int S_IDLE  = 0;
    localparam int S_CLEAR = 1;
    localparam int S_START = 2;
    localparam int S_WAIT  = 3;
    localparam int S_RESP  = 4;
    localparam int NUM_STATES = 5;

    localparam int NUM_REQ_MAX     = 4;
    localparam int TIMEOUT_DEFAULT = 1024;

    // Each state value sets exactly the bit named by its S_* index.
    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE  = 5'b00001,
        ST_CLEAR = 5'b00010,
        ST_START = 5'b00100,
        ST_WAIT  = 5'b01000,
        ST_RESP  = 5'b10000
    } state_t;

    function automatic int index_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/array_check_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_arbiter
    import array_check_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = index_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    output logic [NUM_REQ-1:0] winner,
    output logic [IDX_W-1:0]   winner_index
);

    logic [IDX_W-1:0]   rot_idx [NUM_REQ];
    logic [NUM_REQ-1:0] rot_req;
    logic               found;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_rotate
            assign rot_idx[gi] = IDX_W'((int'(pointer) + gi) % NUM_REQ);
            assign rot_req[gi] = req[rot_idx[gi]];
        end
    endgenerate

    // Offset 0 is the pointer itself, so it has the highest priority.
    always_comb begin
        found        = 1'b0;
        winner_index = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && rot_req[k]) begin
                found        = 1'b1;
                winner_index = rot_idx[k];
            end
        end
    end

    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
            assign winner[gi] = found && (winner_index == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/array_check_scheduler.sv
// Shares one array-sort-check datapath between NUM_REQ requesters: arbitrate,
// reset the datapath, start it, wait for done or timeout, return the result.
module array_check_scheduler
    import array_check_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int LEN_W   = 32,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_base,
    input  logic [NUM_REQ*LEN_W-1:0]    req_len,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          resp_valid,
    output logic                        resp_sorted,
    output logic                        resp_error,
    output logic                        busy,
    output logic                        dp_reset,
    output logic                        dp_go,
    output logic [ADDR_W-1:0]           dp_base,
    output logic [LEN_W-1:0]            dp_length,
    input  logic                        dp_done,
    input  logic                        dp_sorted
);

    localparam int IDX_W = index_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

    state_t             state_reg;
    logic [NUM_REQ-1:0] winner_reg;
    logic [IDX_W-1:0]   ptr_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic               sorted_reg;
    logic               error_reg;
    logic [ADDR_W-1:0]  base_reg;
    logic [LEN_W-1:0]   len_reg;

    logic [NUM_REQ-1:0] arb_winner;
    logic [IDX_W-1:0]   arb_index;
    logic [ADDR_W-1:0]  base_slice [NUM_REQ];
    logic [LEN_W-1:0]   len_slice  [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
            assign base_slice[gi] = req_base[gi*ADDR_W +: ADDR_W];
            assign len_slice[gi]  = req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arbiter (
        .req          (req),
        .pointer      (ptr_reg),
        .winner       (arb_winner),
        .winner_index (arb_index)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            winner_reg <= '0;
            ptr_reg    <= '0;
            cnt_reg    <= '0;
            sorted_reg <= 1'b0;
            error_reg  <= 1'b0;
            base_reg   <= '0;
            len_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        winner_reg <= arb_winner;
                        base_reg   <= base_slice[arb_index];
                        len_reg    <= len_slice[arb_index];
                        ptr_reg    <= (arb_index == IDX_LAST) ? '0 : arb_index + IDX_W'(1);
                        state_reg  <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    state_reg <= ST_START;
                end
                ST_START: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done is checked first so it wins a same-cycle timeout.
                    if (dp_done) begin
                        sorted_reg <= dp_sorted;
                        error_reg  <= 1'b0;
                        state_reg  <= ST_RESP;
                    end else if (cnt_reg == CNT_LAST) begin
                        sorted_reg <= 1'b0;
                        error_reg  <= 1'b1;
                        state_reg  <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // Moore outputs decoded straight from the state and job flops.
    assign busy        = !state_reg[S_IDLE];
    assign grant       = state_reg[S_IDLE] ? '0 : winner_reg;
    assign resp_valid  = state_reg[S_RESP] ? winner_reg : '0;
    assign resp_sorted = sorted_reg;
    assign resp_error  = error_reg;
    assign dp_go       = state_reg[S_START];
    // The datapath's terminal states only exit on reset, so it follows ours too.
    assign dp_reset    = reset | state_reg[S_CLEAR];
    assign dp_base     = base_reg;
    assign dp_length   = len_reg;

endmodule
